// File: rtl/kbd_ctrl_if.sv
// CPU data-memory bus slice seen by the PS/2 keyboard controller.
// The master is the CPU/MMU side and the slave is kbd_ctrl.
interface kbd_ctrl_if;
  logic        sel;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, re, we, addr, din, input dout);
  modport slave  (input sel, re, we, addr, din, output dout);
endinterface

// File: rtl/kbd_ctrl.sv
// Memory-mapped PS/2 keyboard controller: frame receiver, scan-code FIFO, CPU register window.
// Optional KBD_BREAK_DECODE_EN folds 0xE0/0xF0 prefixes into ext/brk bits of the next code.
module kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  kbd_ctrl_if.slave  bus,
  input  logic       ps2_clk,
  input  logic       ps2_dat
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  rx_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   par_q, par_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   rx_en_q, rx_en_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovf_q, ovf_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [9:0]             mem_q [FIFO_DEPTH];

  logic       fall, dat_s, timeout;
  logic       frame_good, perr_set, ferr_set;
  logic       push_req;
  logic [9:0] push_entry;
  logic       empty, full, pop, flush, wr_en, ovf_set;
  logic       status_wr, ctrl_wr;
  logic [9:0] head;
  logic       unused_bus_bits;

`ifdef KBD_BREAK_DECODE_EN
  logic brk_q, brk_d;
  logic ext_q, ext_d;
`endif

  // Synchronizers; reset to the idle-high line level so no edge appears on release.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    fall       = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    dat_s      = dat_sync_q[SYNC_STAGES-1];
    timeout    = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!rx_en_q || timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat_s) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    frame_good = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = timeout;
    wd_d       = (state_q == IDLE || fall || timeout) ? '0 : wd_q + 1'b1;
    if (rx_en_q && !timeout && fall) begin
      case (state_q)
        IDLE:   bit_cnt_d = 3'd0;
        DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: par_d = dat_s;
        STOP: begin
          frame_good = dat_s & (^{par_q, shift_q});
          perr_set   = ~(^{par_q, shift_q});
          ferr_set   = ~dat_s;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status_wr = bus.sel & bus.we & (bus.addr[3:2] == 2'd1);
    ctrl_wr   = bus.sel & bus.we & (bus.addr[3:2] == 2'd2);
    flush     = ctrl_wr & bus.din[1];
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = bus.sel & bus.re & (bus.addr[3:2] == 2'd0) & ~empty;
  end

`ifdef KBD_BREAK_DECODE_EN
  // Prefix bytes only arm the latches; the following code carries them and clears them.
  always_comb begin
    brk_d      = brk_q;
    ext_d      = ext_q;
    push_req   = 1'b0;
    push_entry = {ext_q, brk_q, shift_q};
    if (frame_good) begin
      if (shift_q == 8'hF0)      brk_d = 1'b1;
      else if (shift_q == 8'hE0) ext_d = 1'b1;
      else begin
        push_req = 1'b1;
        brk_d    = 1'b0;
        ext_d    = 1'b0;
      end
    end
    if (flush) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
  end
`else
  always_comb begin
    push_req   = frame_good;
    push_entry = {2'b00, shift_q};
  end
`endif

  // A push into a full FIFO survives only if a pop frees the slot in the same cycle.
  always_comb begin
    wr_en    = push_req & (~full | pop) & ~flush;
    ovf_set  = push_req & full & ~pop & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_d = count_q + 1'b1;
      else if (!wr_en && pop) count_d = count_q - 1'b1;
    end
    perr_d  = (perr_q & ~(status_wr & bus.din[1])) | perr_set;
    ferr_d  = (ferr_q & ~(status_wr & bus.din[2])) | ferr_set;
    ovf_d   = (ovf_q  & ~(status_wr & bus.din[3])) | ovf_set;
    rx_en_d = ctrl_wr ? bus.din[0] : rx_en_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      rx_en_q    <= 1'b1;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef KBD_BREAK_DECODE_EN
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      rx_en_q    <= rx_en_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef KBD_BREAK_DECODE_EN
      brk_q      <= brk_d;
      ext_q      <= ext_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_entry;
  end

  always_comb begin
    head            = mem_q[rd_ptr_q];
    unused_bus_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.din[31:4]};
    case (bus.addr[3:2])
      2'd0:    bus.dout = empty ? '0 : {1'b1, 21'b0, head};
      2'd1:    bus.dout = {16'b0, 8'(count_q), 4'b0, ovf_q, ferr_q, perr_q, empty};
      2'd2:    bus.dout = {31'b0, rx_en_q};
      default: bus.dout = '0;
    endcase
  end

endmodule

// File: doc/kbd_ctrl.md
Name: kbd_ctrl

Overview:
- Memory-mapped PS/2 keyboard controller on the CPU data-memory bus, selected by the MMU keyboard select; its read data feeds the MMU keyboard read-data input.
- Receives PS/2 frames with an FSM, checks them, and queues scan codes in a FIFO.
- The CPU polls and pops codes through a small register window; the controller arbitrates FIFO push (PS/2 side) against pop (CPU side) every cycle.

Parameters:
- FIFO_DEPTH, 8, number of FIFO entries; power of two, 2..64.
- SYNC_STAGES, 2, synchronizer flops on ps2_clk and ps2_dat; minimum 2.
- TIMEOUT_CYCLES, 20000, clock cycles with no PS/2 falling edge mid-frame before the frame is aborted (2 ms at 10 MHz).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- sel  in  1  keyboard region selected by the MMU.
- re  in  1  read strobe; a DATA read with sel & re pops the FIFO.
- we  in  1  write strobe; qualified by sel.
- addr  in  32  byte address; only addr[3:2] decoded.
- din  in  32  write data.
- dout  out  32  read data, combinational from addr[3:2].
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_dat  in  1  raw PS/2 data, asynchronous.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, RX FSM in IDLE, all sticky flags 0, prefix latches 0.
  - dout = 0 while any read targets an empty FIFO.
- Inputs: ps2_clk and ps2_dat pass through SYNC_STAGES flops. A falling edge is synchronized ps2_clk going 1→0 between consecutive cycles; it is a single-cycle strobe.
- RX FSM, advancing only on a falling edge:
  - IDLE: if dat=0 (start bit), go to DATA with bit counter 0; else stay in IDLE.
  - DATA: shift dat in LSB first; after 8 bits, go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: the frame is good if dat=1 and the 9 bits have odd parity. Good → push request for one cycle. Bad → set PERR sticky if parity failed, FERR sticky if the stop bit was 0; no push. Always return to IDLE.
- Watchdog: the counter clears on every falling edge and in IDLE. When it reaches TIMEOUT_CYCLES outside IDLE, go to IDLE, set FERR, and discard the partial frame.
- FIFO: count is 0..FIFO_DEPTH; read and write pointers wrap modulo FIFO_DEPTH.
  - Pop = sel & re & addr[3:2]==0 & !empty.
  - Push on a good frame: when not full, write the entry. When full and no pop in the same cycle, drop the entry and set OVF sticky.
  - Simultaneous push and pop: both take effect and count is unchanged, including when full.
  - Pop when empty: ignored; pointers unchanged.
- Register map (addr[3:2]):
  - 0 DATA: read returns {valid, 21'b0, ext, brk, code[7:0]}, with valid=!empty, bit 31. Returns all zeros when empty. Reads pop (see above).
  - 1 STATUS: read returns {16'b0, count[7:0], 4'b0, OVF, FERR, PERR, empty}. A write with sel&we clears each sticky flag whose din bit (1..3) is 1.
  - 2 CTRL: bit 0 = RX enable, reset 1. When 0, the FSM is held in IDLE and edges are ignored. A write with sel&we & din[1]=1 flushes the FIFO (count→0) in that cycle; a flush wins over a same-cycle push and pop.
  - 3: reads 0, writes ignored.
- Sticky set and clear in the same cycle: set wins.
- Writes never affect the FIFO except a CTRL flush.

Optional Feature:
- Macro: KBD_BREAK_DECODE_EN.
- Defined:
  - A good frame with code 0xF0 sets the brk latch; code 0xE0 sets the ext latch. Neither is pushed.
  - The next other code is pushed with its brk and ext bits set from the latches, and both latches clear on that push (also on a flush or reset).
- Undefined: every good byte, including 0xE0 and 0xF0, is pushed raw; brk and ext read as 0.

Test Plan:
1. Send frame 0x1C with odd parity → STATUS count=1, empty=0. DATA read → 0x8000001C, and count=0 on the next cycle. A second DATA read → 0x00000000.
2. Send 0x1C with a wrong parity bit → no push. STATUS reads 0x00000003 (PERR=1, empty=1). Write STATUS din=0x2 → STATUS reads 0x00000001.
3. Send FIFO_DEPTH+1 good frames (0x01..0x09) with no pops → count=8 and OVF=1. Eight DATA reads return 0x01..0x08 in order.
4. Send start bit plus 3 data bits, then stop ps2_clk for TIMEOUT_CYCLES → FERR=1, FSM in IDLE. A following good frame 0x2A is received correctly.
5. With FIFO full, align a DATA pop with the STOP edge of frame 0x55 → count stays 8, OVF=0, and 0x55 is the last entry. Also pulse reset low mid-frame → all state cleared and count=0.
6. (KBD_BREAK_DECODE_EN) Send frames E0, F0, 75 → one entry, DATA=0x80000375. Undefined build: three entries, 0x800000E0, 0x800000F0, 0x80000075.
